pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Instruction fetch and control-flow sequencer for the cellular-automaton processor core. It owns the 12-bit program counter and the call stack, and fetches 16-bit instructions from instruction memory. JUMP, CALL, RET and UNL resolve locally; all other opcodes are issued to the per-cell datapath through a valid/ready handshake. It sits between instruction memory and the datapath decode stage.

## Interface
- STACK_DEPTH, 32: call-stack entries (≤ 2^stack_pointer_length).
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; permits fetching while high.
- fetch_req  out  1  one-cycle instruction read strobe.
- fetch_addr  out  12  read address (pc_t), valid with fetch_req.
- fetch_valid  in  1  instruction returned; any latency ≥1 cycle after fetch_req.
- fetch_instr  in  16  instruction_t, valid with fetch_valid.
- issue_valid  out  1  non-branch instruction offered to datapath.
- issue_instr  out  16  offered instruction, stable while issue_valid && !issue_ready.
- issue_ready  in  1  datapath accepts/has no pending register write.
- cond_sel  out  4  condition register index (instr[11:8]) during BRANCH.
- cond_value  in  32  value_t, combinational regfile read of cond_sel.
- pc  out  12  current program counter.
- fault  out  1  sticky fault flag.
- fault_code  out  2  0 none, 1 stack overflow, 2 stack underflow, 3 illegal opcode.

## Operation
- States: IDLE, FETCH, WAIT, ISSUE, BRANCH, FAULT.
- IDLE: run=1 → FETCH.
- FETCH: fetch_req=1, fetch_addr=pc → WAIT.
- WAIT: on fetch_valid latch fetch_instr. Opcodes 0–11 → ISSUE; 12–14 → BRANCH; 15 → FAULT, code 3.
- ISSUE: issue_valid=1. Transfer on issue_valid && issue_ready; then pc←pc+1.
- BRANCH: waits for issue_ready=1 so that all prior writes are visible. Then resolves:
  - JUMP: pc←instr[11:0].
  - CALL: push pc+1; pc←instr[11:0].
  - RET: pc←pop.
  - UNL: if cond_value==0, pc←pc+sext(instr[7:0]) (offset relative to the UNL's own address); else pc←pc+1.
- Exit from ISSUE/BRANCH goes to FETCH if run=1, else IDLE. pc is retained.
- PC arithmetic is modulo 4096: 4095+1=0; 2+sext(8'hFC)=4094.
- CALL with STACK_DEPTH entries occupied → FAULT, code 1; pc and stack are unchanged.
- RET on an empty stack → FAULT, code 2.
- FAULT is terminal until rst. No fetch or issue occurs in FAULT.
- fetch_valid outside WAIT is ignored.

## Timing
- Reset values: pc=0, fetch_req=0, fetch_addr=0, issue_valid=0, issue_instr=0, cond_sel=0, fault=0, fault_code=0, stack empty, state IDLE.
- All outputs are registered except cond_sel, which is decoded from the latched instruction.
- Best-case non-branch throughput: 1-cycle memory plus ready = 3 cycles/instruction (FETCH, WAIT, ISSUE).
- Branch with ready held high: 3 cycles to the next FETCH.
- fetch_req is never asserted while a read is outstanding.
- Reset mid-operation aborts any instruction; a late fetch_valid after reset is dropped.
- Push and pop never occur in the same cycle.

## Configuration
- PC_SEQUENCER_CALL_STACK_EN defined: call stack instantiated; CALL/RET behave as above.
- Undefined: no stack storage is instantiated; CALL and RET are illegal opcodes (FAULT, code 3); STACK_DEPTH is unused.

## Structure
- Shared package (isa) gains:
  - seq_state_t enum.
  - fault_code_t (2-bit).
  - FAULT_NONE/FAULT_OVERFLOW/FAULT_UNDERFLOW/FAULT_ILLEGAL constants.
  - Sequencer reuses pc_t, instruction_t, value_t and the existing field-extraction/branch-classification functions.
- Sub-module call_stack: LIFO of pc_t with push, pop, full, empty, top. Occupancy counter is stack_pointer_length+1 bits wide. Instantiated only under PC_SEQUENCER_CALL_STACK_EN.

## Test plan
- Reset, run=1, memory returns ADD at 0,1 with ready=1 → fetch_addr 0,1,2 on cycles 0,3,6; issue_valid carries each ADD; pc=2 after second issue.
- ISSUE with issue_ready low 5 cycles → issue_valid and issue_instr held stable; single transfer; pc increments once.
- CALL 0x100 at pc=0x010, RET at 0x100 → pc 0x100 then 0x011; stack empty afterwards.
- UNL at pc=0x020, offset 8'hF0: cond_value=0 → pc=0x010; cond_value=5 → pc=0x021. UNL at pc=0 offset 8'hFF → pc=0xFFF.
- 33 nested CALLs → fault=1, code 1, pc unchanged, no further fetch_req. RET at reset → code 2. Opcode 0xF → code 3.
- Assert rst during WAIT, then fetch_valid next cycle → instruction ignored, all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared ISA package for the cellular-automaton core: instruction field
// types, opcode map, branch classification and the sequencer's state and
// fault encodings.
//
// Opcode map: 0-11 datapath ops, 12 JUMP, 13 CALL, 14 UNL/RET, 15 illegal.
// RET shares opcode 14 with UNL; a condition index of 15 selects RET, so
// UNL can test registers 0-14 only.
package pc_sequencer_pkg;

    typedef logic [11:0] pc_t;
    typedef logic [15:0] instruction_t;
    typedef logic [31:0] value_t;
    typedef logic [3:0]  opcode_t;
    typedef logic [3:0]  reg_idx_t;

    localparam opcode_t  OP_JUMP    = 4'hC;
    localparam opcode_t  OP_CALL    = 4'hD;
    localparam opcode_t  OP_UNL     = 4'hE;
    localparam opcode_t  OP_ILLEGAL = 4'hF;
    localparam reg_idx_t RET_SELECT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_BRANCH,
        S_FAULT
    } seq_state_t;

    typedef logic [1:0] fault_code_t;
    localparam fault_code_t FAULT_NONE      = 2'd0;
    localparam fault_code_t FAULT_OVERFLOW  = 2'd1;
    localparam fault_code_t FAULT_UNDERFLOW = 2'd2;
    localparam fault_code_t FAULT_ILLEGAL   = 2'd3;

    typedef enum logic [2:0] {
        K_ISSUE,
        K_JUMP,
        K_CALL,
        K_RET,
        K_UNL,
        K_ILLEGAL
    } instr_kind_t;

    function automatic opcode_t opcode_of(instruction_t i);
        return i[15:12];
    endfunction

    function automatic pc_t target_of(instruction_t i);
        return i[11:0];
    endfunction

    function automatic reg_idx_t cond_of(instruction_t i);
        return i[11:8];
    endfunction

    function automatic pc_t sext_offset(instruction_t i);
        return {{4{i[7]}}, i[7:0]};
    endfunction

    // Without a call stack, CALL and RET have nowhere to go and are illegal.
    function automatic instr_kind_t classify(instruction_t i, logic stack_en);
        instr_kind_t k;
        case (opcode_of(i))
            OP_JUMP:    k = K_JUMP;
            OP_CALL:    k = stack_en ? K_CALL : K_ILLEGAL;
            OP_UNL:     k = (cond_of(i) == RET_SELECT) ? (stack_en ? K_RET : K_ILLEGAL) : K_UNL;
            OP_ILLEGAL: k = K_ILLEGAL;
            default:    k = K_ISSUE;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/pc_sequencer_call_stack.sv
// call_stack: LIFO of return addresses for CALL/RET.
// Ports: clk, rst (async, active high), push/din, pop, top (current top
// entry, undefined when empty), full, empty.
// Overflowing push / underflowing pop are ignored; the sequencer faults
// before issuing them.
module call_stack
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  pc_t  din,
    output pc_t  top,
    output logic full,
    output logic empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W:0]   count_q;
    logic [PTR_W-1:0] top_idx;
    pc_t              mem [DEPTH];

    assign full    = (count_q == CNT_MAX);
    assign empty   = (count_q == '0);
    assign top_idx = count_q[PTR_W-1:0] - PTR_ONE;
    assign top     = mem[top_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (push && !full) begin
            count_q <= count_q + CNT_ONE;
        end else if (pop && !empty) begin
            count_q <= count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[count_q[PTR_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction fetch and control-flow sequencer. Owns the
// program counter and call stack, fetches instructions, resolves
// JUMP/CALL/RET/UNL locally and offers everything else to the datapath.
//
// Build option: PC_SEQUENCER_CALL_STACK_EN instantiates the call stack;
// without it CALL and RET fault as illegal opcodes.
//
// Ports:
//   clk, rst                      core clock, async active-high reset
//   run                           level enable for fetching
//   fetch_req/fetch_addr          one-cycle read strobe and address
//   fetch_valid/fetch_instr       returned instruction
//   issue_valid/issue_instr/issue_ready  datapath handshake
//   cond_sel/cond_value           condition register read for UNL
//   pc, fault, fault_code         status
//
// state  | meaning
// IDLE   | parked, waiting for run
// FETCH  | read strobe for pc
// WAIT   | waiting for the instruction to return
// ISSUE  | offering instruction to datapath
// BRANCH | waiting for datapath to drain, then resolving control flow
// FAULT  | terminal until reset
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        fetch_req,
    output logic [11:0] fetch_addr,
    input  logic        fetch_valid,
    input  logic [15:0] fetch_instr,
    output logic        issue_valid,
    output logic [15:0] issue_instr,
    input  logic        issue_ready,
    output logic [3:0]  cond_sel,
    input  logic [31:0] cond_value,
    output logic [11:0] pc,
    output logic        fault,
    output logic [1:0]  fault_code
);

`ifdef PC_SEQUENCER_CALL_STACK_EN
    localparam logic STACK_EN = 1'b1;
`else
    localparam logic STACK_EN = 1'b0;
`endif
    localparam pc_t PC_ONE = 12'd1;

    seq_state_t   state_q, state_n;
    pc_t          pc_q, pc_n;
    instruction_t instr_q, instr_n;
    fault_code_t  fault_code_q, fault_code_n;
    logic         fetch_req_q, issue_valid_q, fault_q;
    pc_t          fetch_addr_q;
    instr_kind_t  kind_latched;

`ifdef PC_SEQUENCER_CALL_STACK_EN
    logic stack_push, stack_pop, stack_full, stack_empty;
    pc_t  stack_top;

    call_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_call_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (stack_push),
        .pop   (stack_pop),
        .din   (pc_q + PC_ONE),
        .top   (stack_top),
        .full  (stack_full),
        .empty (stack_empty)
    );
`endif

    assign kind_latched = classify(instr_q, STACK_EN);

    always_comb begin
        state_n      = state_q;
        pc_n         = pc_q;
        instr_n      = instr_q;
        fault_code_n = fault_code_q;
`ifdef PC_SEQUENCER_CALL_STACK_EN
        stack_push   = 1'b0;
        stack_pop    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (run) state_n = S_FETCH;
            end
            S_FETCH: begin
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (fetch_valid) begin
                    instr_n = fetch_instr;
                    case (classify(fetch_instr, STACK_EN))
                        K_ISSUE: state_n = S_ISSUE;
                        K_ILLEGAL: begin
                            state_n      = S_FAULT;
                            fault_code_n = FAULT_ILLEGAL;
                        end
                        default: state_n = S_BRANCH;
                    endcase
                end
            end
            S_ISSUE: begin
                if (issue_ready) begin
                    pc_n    = pc_q + PC_ONE;
                    state_n = run ? S_FETCH : S_IDLE;
                end
            end
            S_BRANCH: begin
                // Holding here until ready guarantees earlier register
                // writes are visible through cond_value.
                if (issue_ready) begin
                    state_n = run ? S_FETCH : S_IDLE;
                    case (kind_latched)
                        K_JUMP: pc_n = target_of(instr_q);
                        K_UNL:  pc_n = (cond_value == '0) ? pc_q + sext_offset(instr_q)
                                                          : pc_q + PC_ONE;
`ifdef PC_SEQUENCER_CALL_STACK_EN
                        K_CALL: begin
                            if (stack_full) begin
                                state_n      = S_FAULT;
                                fault_code_n = FAULT_OVERFLOW;
                            end else begin
                                stack_push = 1'b1;
                                pc_n       = target_of(instr_q);
                            end
                        end
                        K_RET: begin
                            if (stack_empty) begin
                                state_n      = S_FAULT;
                                fault_code_n = FAULT_UNDERFLOW;
                            end else begin
                                stack_pop = 1'b1;
                                pc_n      = stack_top;
                            end
                        end
`endif
                        default: begin
                            state_n      = S_FAULT;
                            fault_code_n = FAULT_ILLEGAL;
                        end
                    endcase
                end
            end
            S_FAULT: begin
                state_n = S_FAULT;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up
    // with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            instr_q       <= '0;
            fault_code_q  <= FAULT_NONE;
            fetch_req_q   <= 1'b0;
            fetch_addr_q  <= '0;
            issue_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_n;
            pc_q          <= pc_n;
            instr_q       <= instr_n;
            fault_code_q  <= fault_code_n;
            fetch_req_q   <= (state_n == S_FETCH);
            if (state_n == S_FETCH) fetch_addr_q <= pc_n;
            issue_valid_q <= (state_n == S_ISSUE);
            fault_q       <= (state_n == S_FAULT);
        end
    end

    assign fetch_req   = fetch_req_q;
    assign fetch_addr  = fetch_addr_q;
    assign issue_valid = issue_valid_q;
    assign issue_instr = instr_q;
    assign cond_sel    = (state_q == S_BRANCH) ? cond_of(instr_q) : '0;
    assign pc          = pc_q;
    assign fault       = fault_q;
    assign fault_code  = fault_code_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam int DEPTH = 32;
`ifdef PC_SEQUENCER_CALL_STACK_EN
    localparam bit MODEL_STACK = 1'b1;
`else
    localparam bit MODEL_STACK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        fetch_req;
    logic [11:0] fetch_addr;
    logic        fetch_valid = 1'b0;
    logic [15:0] fetch_instr = '0;
    logic        issue_valid;
    logic [15:0] issue_instr;
    logic        issue_ready = 1'b0;
    logic [3:0]  cond_sel;
    logic [31:0] cond_value;
    logic [11:0] pc;
    logic        fault;
    logic [1:0]  fault_code;

    logic [31:0] regs [16];
    logic [15:0] mem  [4096];
    assign cond_value = regs[cond_sel];

    pc_sequencer #(.STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .run(run),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
        .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_ready(issue_ready),
        .cond_sel(cond_sel), .cond_value(cond_value),
        .pc(pc), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [11:0] pc; logic [15:0] ins; } iss_t;

    int         checks = 0;
    int         failures = 0;
    logic [11:0] exp_fetch[$];
    iss_t       exp_issue[$];
    int         fetch_stamps[$];
    int         n_fetch = 0;
    int         cyc = 0;

    int          m_pc = 0;
    logic [11:0] m_stk[$];
    bit          exp_fault = 0;
    int          exp_code = 0;

    bit mem_en = 1, junk_en = 0;
    int lat_max = 1;
    int ready_mode = 1;
    int stall_left = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(string name, logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=0x%0h required=none", name, act);
    endtask

    // Architectural interpreter: walks k instructions from the model pc.
    task automatic model(int k);
        logic [15:0] ins;
        int off;
        for (int s = 0; s < k && !exp_fault; s++) begin
            ins = mem[m_pc];
            exp_fetch.push_back(12'(m_pc));
            case (ins[15:12])
                4'hF: begin exp_fault = 1; exp_code = 3; end
                4'hC: m_pc = int'(ins[11:0]);
                4'hD: begin
                    if (!MODEL_STACK) begin exp_fault = 1; exp_code = 3; end
                    else if (m_stk.size() == DEPTH) begin exp_fault = 1; exp_code = 1; end
                    else begin m_stk.push_back(12'((m_pc + 1) & 4095)); m_pc = int'(ins[11:0]); end
                end
                4'hE: begin
                    if (ins[11:8] == 4'hF) begin
                        if (!MODEL_STACK) begin exp_fault = 1; exp_code = 3; end
                        else if (m_stk.size() == 0) begin exp_fault = 1; exp_code = 2; end
                        else m_pc = int'(m_stk.pop_back());
                    end else if (regs[ins[11:8]] == 0) begin
                        off = $signed(ins[7:0]);
                        m_pc = (m_pc + off) & 4095;
                    end else begin
                        m_pc = (m_pc + 1) & 4095;
                    end
                end
                default: begin
                    exp_issue.push_back({12'(m_pc), ins});
                    m_pc = (m_pc + 1) & 4095;
                end
            endcase
        end
    endtask

    // Instruction memory with random latency and stray valid pulses.
    initial begin
        bit pending = 0;
        int lat_left = 0;
        logic [11:0] req_addr = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_en) begin
                fetch_valid = 1'b0;
                if (rst) pending = 0;
                else if (pending) begin
                    if (lat_left == 0) begin
                        fetch_valid = 1'b1;
                        fetch_instr = mem[req_addr];
                        pending = 0;
                    end else lat_left--;
                end else if (junk_en && $urandom_range(0, 5) == 0) begin
                    fetch_valid = 1'b1;
                    fetch_instr = 16'($urandom);
                end
                if (!rst && fetch_req && !pending) begin
                    pending = 1;
                    req_addr = fetch_addr;
                    lat_left = $urandom_range(0, lat_max - 1);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: issue_ready = ($urandom_range(0, 2) != 0);
                1: issue_ready = 1'b1;
                3: begin
                    if (issue_valid && stall_left > 0) begin
                        issue_ready = 1'b0;
                        stall_left--;
                    end else issue_ready = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Monitor: pops expectations whenever the DUT presents a fetch or issue.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (fetch_req) begin
                    n_fetch++;
                    fetch_stamps.push_back(cyc);
                    if (exp_fetch.size() == 0) flag_fail("unexpected_fetch", 32'(fetch_addr));
                    else check("fetch_addr", fetch_addr, exp_fetch.pop_front());
                end
                if (issue_valid) begin
                    if (exp_issue.size() == 0) flag_fail("unexpected_issue", 32'(issue_instr));
                    else begin
                        check("issue_instr", issue_instr, exp_issue[0].ins);
                        check("issue_pc", pc, exp_issue[0].pc);
                        if (issue_ready) void'(exp_issue.pop_front());
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #3;
        rst = 1'b1;
        run = 1'b0;
        exp_fetch.delete();
        exp_issue.delete();
        m_stk.delete();
        m_pc = 0;
        exp_fault = 0;
        exp_code = 0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
    endtask

    task automatic exec(int k);
        int t;
        int saved;
        model(k);
        run = 1'b1;
        t = 0;
        while (exp_fetch.size() != 0 && t < 3000) begin @(posedge clk); #2; t++; end
        check("fetch_drained", exp_fetch.size(), 0);
        run = 1'b0;
        saved = ready_mode;
        if (ready_mode == 0) ready_mode = 1;
        t = 0;
        while (exp_issue.size() != 0 && t < 200) begin @(posedge clk); #2; t++; end
        repeat (8) @(posedge clk);
        #2;
        check("issue_drained", exp_issue.size(), 0);
        check("pc", pc, m_pc);
        check("fault", fault, exp_fault);
        check("fault_code", fault_code, exp_code);
        ready_mode = saved;
    endtask

    task automatic check_reset_values(string tag);
        check({tag, "_pc"}, pc, 0);
        check({tag, "_fetch_req"}, fetch_req, 0);
        check({tag, "_fetch_addr"}, fetch_addr, 0);
        check({tag, "_issue_valid"}, issue_valid, 0);
        check({tag, "_issue_instr"}, issue_instr, 0);
        check({tag, "_cond_sel"}, cond_sel, 0);
        check({tag, "_fault"}, fault, 0);
        check({tag, "_fault_code"}, fault_code, 0);
        check({tag, "_state"}, dut.state_q, S_IDLE);
    endtask

    function automatic logic [15:0] gen();
        int r;
        logic [7:0] o;
        r = $urandom_range(0, 99);
        o = 8'($urandom_range(0, 15)) - 8'd8;
        if (r < 55) return {4'($urandom_range(0, 11)), 12'($urandom)};
        if (r < 67) return {OP_JUMP, 12'($urandom_range(0, 63))};
        if (r < 85) return {OP_UNL, 4'($urandom_range(0, 3)), o};
        if (r < 93) return {OP_CALL, 12'($urandom_range(0, 63))};
        if (r < 98) return {OP_UNL, 4'hF, 8'h00};
        return {OP_ILLEGAL, 12'($urandom)};
    endfunction

    initial begin
        int n0;
        for (int i = 0; i < 16; i++) regs[i] = '0;
        for (int i = 0; i < 4096; i++) mem[i] = '0;

        do_reset();
        @(negedge clk);
        check_reset_values("reset");

        // Back-to-back datapath ops with 1-cycle memory and ready high.
        mem[0] = 16'h0123; mem[1] = 16'h1456; mem[2] = 16'h2789;
        fetch_stamps.delete();
        exec(3);
        check("thru_gap0", fetch_stamps[1] - fetch_stamps[0], 3);
        check("thru_gap1", fetch_stamps[2] - fetch_stamps[1], 3);

        // Branch to next fetch spacing.
        do_reset();
        mem[0] = {OP_JUMP, 12'h005}; mem[5] = 16'h0111;
        fetch_stamps.delete();
        exec(2);
        check("branch_gap", fetch_stamps[1] - fetch_stamps[0], 3);

        // Datapath back-pressure for 5 cycles.
        do_reset();
        ready_mode = 3; stall_left = 5;
        mem[0] = 16'h0ABC;
        exec(1);
        check("stall_consumed", stall_left, 0);
        ready_mode = 1;

        // CALL / RET round trip, then RET on the emptied stack.
        do_reset();
        mem[0] = {OP_JUMP, 12'h010}; mem[12'h010] = {OP_CALL, 12'h100};
        mem[12'h100] = {OP_UNL, 4'hF, 8'h00}; mem[12'h011] = 16'h0222;
        mem[12'h012] = {OP_UNL, 4'hF, 8'h00};
        exec(4);
        exec(1);

        // UNL taken / not taken, negative wrap, and pc wrap on increment.
        do_reset();
        regs[3] = 0;
        mem[0] = {OP_JUMP, 12'h020}; mem[12'h020] = {OP_UNL, 4'h3, 8'hF0};
        exec(2);
        regs[3] = 5;
        mem[12'h010] = {OP_JUMP, 12'h020};
        exec(2);
        do_reset();
        regs[3] = 0;
        mem[0] = {OP_UNL, 4'h3, 8'hFF}; mem[12'hFFF] = 16'h0333;
        exec(1);
        exec(1);

        // Nested CALLs until overflow; nothing fetched afterwards.
        do_reset();
        for (int i = 0; i <= DEPTH; i++) mem[i] = {OP_CALL, 12'(i + 1)};
        exec(DEPTH + 1);
        n0 = n_fetch;
        run = 1'b1;
        repeat (20) @(posedge clk);
        #2 run = 1'b0;
        check("fault_no_fetch", n_fetch - n0, 0);
        check("fault_sticky", fault, exp_fault);

        // RET straight after reset, and the illegal opcode.
        do_reset();
        mem[0] = {OP_UNL, 4'hF, 8'h00};
        exec(1);
        do_reset();
        mem[0] = 16'hF123;
        exec(1);

        // Reset during WAIT, with a late instruction arriving afterwards.
        do_reset();
        mem_en = 0;
        exp_fetch.push_back(12'h000);
        run = 1'b1;
        n0 = 0;
        while (!fetch_req && n0 < 20) begin @(negedge clk); n0++; end
        check("mid_fetch_seen", fetch_req, 1);
        run = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        fetch_valid = 1'b1;
        fetch_instr = 16'h0ABC;
        @(posedge clk); #1;
        fetch_valid = 1'b0;
        @(negedge clk);
        check_reset_values("midrst");
        mem_en = 1;

        // Randomized programs with random latency, ready and stray valids.
        junk_en = 1; lat_max = 3; ready_mode = 0;
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int i = 0; i < 4096; i++) mem[i] = gen();
            for (int i = 0; i < 4; i++) regs[i] = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
            exec(40);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
